// File: rtl/cache_assoc_pkg.sv
// Shared types and default geometry for the
// set-associative write-back cache.
package cache_assoc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WBACK,
    S_REFILL,
    S_RESP
  } state_e;

  localparam int ADDR_W_D    = 10;
  localparam int DATA_W_D    = 32;
  localparam int BLK_WORDS_D = 4;
  localparam int NUM_SETS_D  = 4;
  localparam int NUM_WAYS_D  = 2;

  // width of an index into n items, at least one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OFF_W_D = $clog2(BLK_WORDS_D);
  localparam int IDX_W_D = $clog2(NUM_SETS_D);
  localparam int TAG_W_D =
    ADDR_W_D - 2 - OFF_W_D - IDX_W_D;
  localparam int AGE_W_D = clog2_min1(NUM_WAYS_D);

endpackage

// File: rtl/cache_tag_array.sv
// Tag, valid, dirty and LRU-age storage with a
// combinational lookup and a single update port.
module cache_tag_array
  import cache_assoc_pkg::*;
#(
  parameter int NUM_SETS = NUM_SETS_D,
  parameter int NUM_WAYS = NUM_WAYS_D,
  parameter int TAG_W    = TAG_W_D,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = clog2_min1(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lk_set,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [WAY_W-1:0] lk_way,
  output logic [WAY_W-1:0] vic_way,
  output logic             vic_dirty,
  output logic [TAG_W-1:0] vic_tag,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_fill,
  input  logic             upd_wr
);

  logic valid_q [NUM_SETS][NUM_WAYS];
  logic valid_d [NUM_SETS][NUM_WAYS];
  logic dirty_q [NUM_SETS][NUM_WAYS];
  logic dirty_d [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_d [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] age_cur [NUM_WAYS];

  // tag compare across all ways of the set
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_set][w] &&
          tag_q[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // lowest invalid way, else the oldest way
  always_comb begin
    logic             found;
    logic [WAY_W-1:0] best;
    found   = 1'b0;
    vic_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lk_set][w]) begin
        vic_way = WAY_W'(w);
        found   = 1'b1;
      end
    end
    best = age_cur[0];
    if (!found) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (age_cur[w] > best) begin
          best    = age_cur[w];
          vic_way = WAY_W'(w);
        end
      end
    end
    vic_dirty = valid_q[lk_set][vic_way] &
                dirty_q[lk_set][vic_way];
    vic_tag   = tag_q[lk_set][vic_way];
  end

  if (NUM_WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] age_d [NUM_SETS][NUM_WAYS];

    // ages of the looked-up set
    always_comb begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_cur[w] = age_q[lk_set][w];
    end

    // touched way becomes youngest, younger ones age
    always_comb begin
      age_d = age_q;
      if (upd_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == upd_way)
            age_d[upd_set][w] = '0;
          else if (age_q[upd_set][w] <
                   age_q[upd_set][upd_way])
            age_d[upd_set][w] =
              age_q[upd_set][w] + 1'b1;
        end
      end
    end

    // age registers, way w starts at age w
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++)
            age_q[s][w] <= WAY_W'(w);
      end else begin
        age_q <= age_d;
      end
    end
  end else begin : g_dm
    // direct-mapped: no replacement state
    always_comb begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_cur[w] = '0;
    end
  end

  // line install / dirty marking
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (upd_en) begin
      valid_d[upd_set][upd_way] = 1'b1;
      tag_d[upd_set][upd_way]   = upd_tag;
      dirty_d[upd_set][upd_way] = upd_wr |
        (dirty_q[upd_set][upd_way] & ~upd_fill);
    end
  end

  // valid/dirty registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // tags are qualified by valid, no reset needed
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-back, write-allocate cache
// with a word-serial memory port.
module cache_assoc
  import cache_assoc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int BLK_WORDS = BLK_WORDS_D,
  parameter int NUM_SETS  = NUM_SETS_D,
  parameter int NUM_WAYS  = NUM_WAYS_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int WAY_W = clog2_min1(NUM_WAYS);
  localparam logic [OFF_W-1:0] LAST =
    OFF_W'(BLK_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [DATA_W-1:0]
    data_q [NUM_SETS][NUM_WAYS][BLK_WORDS];
  logic [DATA_W-1:0]
    data_d [NUM_SETS][NUM_WAYS][BLK_WORDS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             lk_hit, vic_dirty;
  logic [WAY_W-1:0] lk_way, vic_way;
  logic [TAG_W-1:0] vic_tag;
  logic             upd_en, upd_fill, upd_wr;
  logic [WAY_W-1:0] upd_way;
  logic             done, done_hit;
  logic [WAY_W-1:0] done_way;
  logic             unused_addr;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-3 -: TAG_W];
  assign unused_addr = ^cpu_addr[1:0];

  cache_tag_array #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .TAG_W    (TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_set    (idx),
    .lk_tag    (tag),
    .lk_hit    (lk_hit),
    .lk_way    (lk_way),
    .vic_way   (vic_way),
    .vic_dirty (vic_dirty),
    .vic_tag   (vic_tag),
    .upd_en    (upd_en),
    .upd_set   (idx),
    .upd_way   (upd_way),
    .upd_tag   (tag),
    .upd_fill  (upd_fill),
    .upd_wr    (upd_wr)
  );

  // access sequencing and memory transfers
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    way_d       = way_q;
    vtag_d      = vtag_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = cpu_hit_q;
    cpu_rdata_d = cpu_rdata_q;
    data_d      = data_q;
    upd_en      = 1'b0;
    upd_way     = way_q;
    upd_fill    = 1'b0;
    upd_wr      = 1'b0;
    done        = 1'b0;
    done_hit    = 1'b0;
    done_way    = way_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr[ADDR_W-1:2];
          rw_d    = cpu_rw;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cnt_d = '0;
        if (lk_hit) begin
          way_d    = lk_way;
          done     = 1'b1;
          done_hit = 1'b1;
          done_way = lk_way;
        end else begin
          way_d   = vic_way;
          vtag_d  = vic_tag;
          state_d = vic_dirty ? S_WBACK : S_REFILL;
        end
      end
      S_WBACK: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {vtag_q, idx, cnt_q, 2'b00};
          mem_wdata_d = data_q[idx][way_q][cnt_q];
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, idx, cnt_q, 2'b00};
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          data_d[idx][way_q][cnt_q] = mem_rdata;
          if (cnt_q == LAST) begin
            upd_fill = 1'b1;
            done     = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (done) begin
      state_d     = S_RESP;
      cpu_ready_d = 1'b1;
      cpu_hit_d   = done_hit;
      upd_en      = 1'b1;
      upd_way     = done_way;
      upd_wr      = rw_q;
      if (rw_q)
        data_d[idx][done_way][off] = wdata_q;
      else
        cpu_rdata_d = data_d[idx][done_way][off];
    end
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      way_q       <= '0;
      vtag_q      <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      way_q       <= way_d;
      vtag_q      <= vtag_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // data words are qualified by valid, no reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_assoc.sv
// Randomized scoreboard bench for cache_assoc plus a
// direct-mapped 8-word-block instance.
module tb_cache_assoc;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_rw;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        d_req, d_rw;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ready, d_hit;
  logic [31:0] d_rdata;
  logic        d_mreq, d_mwe, d_mack;
  logic [9:0]  d_maddr;
  logic [31:0] d_mwdata, d_mrdata;

  cache_assoc #(
    .ADDR_W(10), .DATA_W(32), .BLK_WORDS(BW),
    .NUM_SETS(NS), .NUM_WAYS(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  cache_assoc #(
    .ADDR_W(10), .DATA_W(32), .BLK_WORDS(8),
    .NUM_SETS(4), .NUM_WAYS(1)
  ) dut_dm (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(d_req), .cpu_rw(d_rw),
    .cpu_addr(d_addr), .cpu_wdata(d_wdata),
    .cpu_ready(d_ready), .cpu_rdata(d_rdata),
    .cpu_hit(d_hit),
    .mem_req(d_mreq), .mem_we(d_mwe),
    .mem_addr(d_maddr), .mem_wdata(d_mwdata),
    .mem_rdata(d_mrdata), .mem_ack(d_mack)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // backing memory and CPU-visible reference memory
  logic [31:0] bmem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] dmem [256];
  int          ack_delay = 0;
  int          n_ack = 0;
  int          d_n_ack = 0;
  logic [9:0]  log_addr [$];
  logic        log_we [$];
  logic [31:0] log_data [$];

  // main memory responder with stability check
  initial begin
    int          wcnt;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic        we0, stable;
    mem_ack = 1'b0; mem_rdata = '0;
    wcnt = 0; a0 = '0; d0 = '0;
    we0 = 1'b0; stable = 1'b1;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && rst_n) begin
        if (wcnt == 0) begin
          a0 = mem_addr; d0 = mem_wdata;
          we0 = mem_we; stable = 1'b1;
        end else if (mem_addr !== a0 ||
                     mem_wdata !== d0 ||
                     mem_we !== we0) begin
          stable = 1'b0;
        end
        if (wcnt >= ack_delay) begin
          check("mem_stable", 32'(stable), 32'd1);
          mem_ack = 1'b1;
          if (mem_we)
            bmem[mem_addr[9:2]] = mem_wdata;
          else
            mem_rdata = bmem[mem_addr[9:2]];
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_data.push_back(mem_wdata);
          n_ack++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // direct-mapped instance memory, immediate ack
  initial begin
    d_mack = 1'b0; d_mrdata = '0;
    forever begin
      @(negedge clk);
      if (d_mack) begin
        d_mack = 1'b0;
      end else if (d_mreq && rst_n) begin
        d_mack = 1'b1;
        if (d_mwe) dmem[d_maddr[9:2]] = d_mwdata;
        else       d_mrdata = dmem[d_maddr[9:2]];
        d_n_ack++;
      end
    end
  end

  // reference model: per set, tags in recency order
  logic [3:0] m_tag [NS][NW];
  logic       m_dirty [NS][NW];
  int         m_cnt [NS];

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = bmem[i];
  endtask

  task automatic model_access(input logic rw,
                              input logic [9:0] a,
                              output logic hit,
                              output logic wb);
    int s, pos;
    logic [3:0] t;
    logic d;
    s = int'(a[5:4]); t = a[9:6];
    hit = 1'b0; wb = 1'b0; pos = -1;
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      d = m_dirty[s][pos] | rw;
    end else begin
      d = rw;
      if (m_cnt[s] == NW) begin
        wb = m_dirty[s][NW-1];
        pos = NW - 1;
      end else begin
        pos = m_cnt[s];
        m_cnt[s]++;
      end
    end
    for (int i = pos; i > 0; i--) begin
      m_tag[s][i]   = m_tag[s][i-1];
      m_dirty[s][i] = m_dirty[s][i-1];
    end
    m_tag[s][0] = t;
    m_dirty[s][0] = d;
  endtask

  typedef struct {
    logic        hit;
    logic        rw;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && cpu_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("cpu_hit", 32'(cpu_hit), 32'(mon_e.hit));
        if (!mon_e.rw)
          check("cpu_rdata", cpu_rdata, mon_e.rdata);
      end
    end
  end

  task automatic do_reset();
    cpu_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
  endtask

  task automatic access(input logic rw,
                        input logic [9:0] a,
                        input logic [31:0] wd);
    exp_t e;
    logic hit, wb;
    int n0, lat;
    bit ok;
    model_access(rw, a, hit, wb);
    e.hit = hit; e.rw = rw;
    e.rdata = ref_mem[a[9:2]];
    if (rw) ref_mem[a[9:2]] = wd;
    sb.push_back(e);
    n0 = n_ack;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw;
    cpu_addr = a; cpu_wdata = wd;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready) ok = 1'b1;
    end
    cpu_req = 1'b0;
    check("ready_seen", 32'(ok), 32'd1);
    if (hit) check("hit_latency", lat, 2);
    check("mem_words", n_ack - n0,
          hit ? 0 : (wb ? 2 * BW : BW));
    @(posedge clk);
  endtask

  task automatic dm_access(input logic rw,
                           input logic [9:0] a,
                           input logic [31:0] wd,
                           input logic ehit,
                           input int ewords,
                           input logic [31:0] erd);
    int n0, lat;
    bit ok;
    n0 = d_n_ack;
    @(negedge clk);
    d_req = 1'b1; d_rw = rw;
    d_addr = a; d_wdata = wd;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (d_ready) ok = 1'b1;
    end
    d_req = 1'b0;
    check("dm_ready_seen", 32'(ok), 32'd1);
    check("dm_hit", 32'(d_hit), 32'(ehit));
    check("dm_words", d_n_ack - n0, ewords);
    if (!rw) check("dm_rdata", d_rdata, erd);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int l0, n0, cyc;
    logic [31:0] x;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_rw = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    d_req = 1'b0; d_rw = 1'b0;
    d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = $urandom;
      dmem[i] = 32'hA500_0000 + 32'(i);
    end
    bmem[16] = 32'h11;
    do_reset();

    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_hit", 32'(cpu_hit), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // cold read then hit
    l0 = log_addr.size();
    access(1'b0, 10'h040, '0);
    for (int i = 0; i < BW; i++) begin
      check("cold_addr", 32'(log_addr[l0+i]),
            32'h40 + 32'(4 * i));
      check("cold_we", 32'(log_we[l0+i]), 32'd0);
    end
    access(1'b0, 10'h040, '0);

    // write hit then dirty eviction in set 0
    access(1'b1, 10'h040, 32'hDEAD);
    access(1'b0, 10'h100, '0);
    l0 = log_addr.size();
    access(1'b0, 10'h200, '0);
    for (int i = 0; i < BW; i++) begin
      check("wb_addr", 32'(log_addr[l0+i]),
            32'h40 + 32'(4 * i));
      check("wb_we", 32'(log_we[l0+i]), 32'd1);
      check("rf_addr", 32'(log_addr[l0+BW+i]),
            32'h200 + 32'(4 * i));
      check("rf_we", 32'(log_we[l0+BW+i]), 32'd0);
    end
    check("wb_word0", log_data[l0], 32'hDEAD);

    // LRU in set 1
    access(1'b0, 10'h010, '0);
    access(1'b0, 10'h110, '0);
    access(1'b0, 10'h010, '0);
    access(1'b0, 10'h210, '0);
    access(1'b0, 10'h010, '0);
    access(1'b0, 10'h110, '0);

    // stalled handshake
    ack_delay = 5;
    access(1'b0, 10'h3F0, '0);
    access(1'b1, 10'h3F4, 32'h1234_5678);
    access(1'b0, 10'h0F8, '0);
    access(1'b0, 10'h1F0, '0);
    access(1'b0, 10'h3F4, '0);
    ack_delay = 0;

    // reset in the middle of a refill
    n0 = n_ack;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0;
    cpu_addr = 10'h2A0;
    cyc = 0;
    while (n_ack < n0 + 2 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check("midrst_words_reached", n_ack - n0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("midrst_mem_req_held", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    access(1'b0, 10'h2A0, '0);
    access(1'b0, 10'h040, '0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [9:0] a;
      a = {4'($urandom_range(0, 5)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'b00};
      ack_delay = $urandom_range(0, 2);
      access(1'($urandom_range(0, 1)), a, $urandom);
    end
    ack_delay = 0;
    check("sb_drained", sb.size(), 0);

    // direct-mapped, 8-word blocks, conflicting tags
    do_reset();
    x = 32'hCAFE_F00D;
    dm_access(1'b0, 10'h000, '0, 1'b0, 8, dmem[0]);
    dm_access(1'b0, 10'h084, '0, 1'b0, 8, dmem[33]);
    dm_access(1'b0, 10'h000, '0, 1'b0, 8, dmem[0]);
    dm_access(1'b1, 10'h004, x, 1'b1, 0, '0);
    dm_access(1'b0, 10'h080, '0, 1'b0, 16, dmem[32]);
    check("dm_wb_data", dmem[1], x);
    dm_access(1'b0, 10'h004, '0, 1'b0, 8, x);
    dm_access(1'b0, 10'h080, '0, 1'b0, 8, dmem[32]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameters SHALL be: ADDR_W=10, byte address width; DATA_W=32, word width; BLK_WORDS=4, words per block (power of 2); NUM_SETS=4, sets (power of 2); NUM_WAYS=2, ways per set (power of 2, 1..8).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request, held high until cpu_ready.
REQ-005 cpu_rw  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-007 cpu_wdata  input  DATA_W  write word.
REQ-008 cpu_ready  output  1  one-cycle pulse: access complete.
REQ-009 cpu_rdata  output  DATA_W  read word, valid when cpu_ready is high and cpu_rw=0.
REQ-010 cpu_hit  output  1  valid with cpu_ready; 1 = hit, 0 = miss.
REQ-011 mem_req, mem_we  output  1 each  memory word request and write enable.
REQ-012 mem_addr  output  ADDR_W  word-aligned memory byte address.
REQ-013 mem_wdata  output  DATA_W; mem_rdata  input  DATA_W; mem_ack  input  1  one-cycle word acknowledge.

Function
REQ-014 Address split SHALL be: tag | set index (log2 NUM_SETS) | word offset (log2 BLK_WORDS) | byte [1:0].
REQ-015 Policy SHALL be write-back, write-allocate, with one valid bit, one dirty bit and one LRU age per line.
REQ-016 FSM states SHALL be IDLE, LOOKUP, WBACK, REFILL, RESP.
- IDLE -> LOOKUP on cpu_req; address, rw and wdata are latched.
REQ-017 LOOKUP SHALL branch as follows:
- Hit -> RESP.
- Miss with a clean or invalid victim -> REFILL.
- Miss with a dirty victim -> WBACK.
REQ-018 Hit latency SHALL be 2 cycles from the cycle cpu_req is sampled to the cycle cpu_ready is high.
REQ-019 Victim choice SHALL be the lowest-index invalid way if any exists; otherwise the way with the maximum LRU age.
REQ-020 WBACK SHALL write BLK_WORDS words, offset 0 upward, with mem_we=1, then go to REFILL.
REQ-021 REFILL SHALL read BLK_WORDS words, offset 0 upward, with mem_we=0, then set valid=1, dirty=0, store the tag, and go to RESP.
REQ-022 Memory handshake SHALL hold mem_req and mem_addr/mem_wdata stable until mem_ack.
- One word transfers per mem_ack.
- mem_req drops for at least one cycle between words.
- mem_ack while mem_req is low is ignored.
REQ-023 RESP SHALL pulse cpu_ready for 1 cycle, then return to IDLE.
- Read: cpu_rdata is the selected word.
- Write: the word is updated and dirty=1.
- cpu_hit reports the LOOKUP result.
REQ-024 On every completed access, the accessed way SHALL get age 0; ways in the same set younger than its old age increment; other ages are unchanged.
REQ-025 With NUM_WAYS=1 the block SHALL behave as direct-mapped, with no LRU storage.
REQ-026 cpu_req high in RESP SHALL be ignored until IDLE, so back-to-back requests see a 1-cycle gap.
REQ-027 cpu_rdata SHALL hold its last value when cpu_ready is low.

Reset
REQ-028 With rst_n low at a clock edge, the block SHALL enter IDLE and clear all valid and dirty bits.
- Way w ages reset to w.
- cpu_ready, cpu_hit, mem_req, mem_we are 0; cpu_rdata, mem_addr, mem_wdata are 0.
REQ-029 Reset during WBACK or REFILL SHALL abort the transfer; mem_req SHALL be low in the cycle after the reset edge; no line becomes valid.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, default parameter values and derived widths (offset, index, tag, age).
REQ-031 Tag/valid/dirty/age storage SHALL be one sub-module, cache_tag_array, with a combinational lookup and registered update; data storage stays in cache_assoc.

Verification
REQ-032 Cold read: reset, read addr 0x040 with memory word value 0x11 -> 4 mem reads at 0x040..0x04C, cpu_hit=0, cpu_rdata=0x11; a repeat read gives cpu_hit=1 in 2 cycles with no mem_req.
REQ-033 Write hit then eviction: write 0xDEAD to 0x040, then read two more tags mapping to set 0 -> the second miss performs WBACK of 0x040..0x04C with word 0 = 0xDEAD before REFILL.
REQ-034 LRU: fill both ways of set 1 (A, B), reread A, miss on C -> B is evicted; a reread of A hits.
REQ-035 Handshake stall: mem_ack delayed 5 cycles per word -> mem_req/mem_addr stay stable; the result is unchanged.
REQ-036 Reset mid-REFILL after 2 words -> mem_req is 0 next cycle; a rereading access misses.
REQ-037 Parameter sweep with NUM_WAYS=1, BLK_WORDS=8 -> the conflict sequence evicts on every alternating tag; transfers are 8 words each.
